// File: rtl/aes_mode_ctrl.sv
// aes_mode_ctrl: block-cipher mode sequencer (ECB/CBC/CFB/OFB) around a shared AES-128 core
module aes_mode_ctrl #(
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       cfg_mode,
  input  logic [127:0]     cfg_key,
  input  logic [127:0]     cfg_iv,
  input  logic             cfg_load,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_data,
  output logic             core_start,
  output logic [127:0]     core_in,
  output logic [127:0]     core_key,
  input  logic [127:0]     core_out,
  input  logic             core_done,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] blk_count
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [2:0] {IDLE, START, WAIT, OUT, ERR} state_t;
  state_t state, nxt;
  logic [TW-1:0] tcnt;
  logic [1:0] mode;
  logic [127:0] chain, pdata, res;
  logic load, acc, done_w, tmo, ohs;
  always_comb begin
    load       = cfg_load && (state == IDLE || state == ERR);
    in_ready   = state == IDLE && !cfg_load;
    acc        = in_ready && in_valid;
    done_w     = state == WAIT && core_done;
    tmo        = state == WAIT && !core_done && tcnt == TW'(TIMEOUT_CYC - 1);
    ohs        = state == OUT && out_ready;
    res        = mode[1] ? pdata ^ core_out : core_out;
    core_start = state == START;
    busy       = state != IDLE;
    out_valid  = state == OUT;
    nxt        = load ? IDLE : acc ? START : state == START ? WAIT : done_w ? OUT : tmo ? ERR : ohs ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      tcnt      <= '0;
      mode      <= 2'd0;
      core_key  <= '0;
      chain     <= '0;
      pdata     <= '0;
      core_in   <= '0;
      out_data  <= '0;
      blk_count <= '0;
      err       <= 1'b0;
    end else begin
      state <= nxt;
      tcnt  <= state == WAIT ? tcnt + 1'b1 : '0;
      if (load) begin
        mode      <= cfg_mode;
        core_key  <= cfg_key;
        chain     <= cfg_iv;
        blk_count <= '0;
        err       <= 1'b0;
      end
      if (acc) begin
        pdata   <= in_data;
        core_in <= mode == 2'd0 ? in_data : mode == 2'd1 ? in_data ^ chain : chain;
      end
      if (done_w) begin
        out_data <= res;
        chain    <= mode == 2'd0 ? chain : mode == 2'd3 ? core_out : res;
      end
      if (tmo) err <= 1'b1;
      if (ohs) blk_count <= blk_count + 1'b1;
    end
  end
endmodule
